// File: rtl/axo_defines.sv
// axo_defines: shared access-size encodings and LSU state type.
package axo_defines;
  localparam logic [1:0] AXO_ASIZE_B = 2'd0;
  localparam logic [1:0] AXO_ASIZE_H = 2'd1;
  localparam logic [1:0] AXO_ASIZE_W = 2'd2;
  localparam logic [1:0] AXO_ASIZE_D = 2'd3;
  typedef enum logic [1:0] {LSU_IDLE, LSU_ACCESS, LSU_DONE} lsu_state_e;
endpackage

// File: rtl/axo_functions.sv
// axo_functions: width-independent helpers shared by LSU, ALU and CSR paths.
package axo_functions;
  import axo_defines::*;
  // Extends a right-justified 1/2/4/8-byte value to 64 bits; callers truncate to XLEN.
  function automatic logic [63:0] axo_sext(input logic [63:0] data, input logic [1:0] asize, input logic sgn);
    return asize == AXO_ASIZE_B ? {{56{sgn & data[7]}}, data[7:0]} :
           asize == AXO_ASIZE_H ? {{48{sgn & data[15]}}, data[15:0]} :
           asize == AXO_ASIZE_W ? {{32{sgn & data[31]}}, data[31:0]} : data;
  endfunction
endpackage

// File: rtl/axo_lsu_align.sv
// axo_lsu_align: request classification (fault/split) and load-data extension.
//   i_asize, i_addr_lo    -> o_fault, o_split : classify an incoming request
//   i_data, i_ld_asize, i_ld_signed -> o_data : extend assembled load data to XLEN
module axo_lsu_align import axo_defines::*, axo_functions::*; #(
  parameter int XLEN       = 32,
  parameter bit MISALIGNED = 1
) (
  input  logic [1:0]      i_asize,
  input  logic [2:0]      i_addr_lo,
  output logic            o_fault,
  output logic            o_split,
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_ld_asize,
  input  logic            i_ld_signed,
  output logic [XLEN-1:0] o_data
);
  logic w_misal;
  // 3-bit mask arithmetic wraps so asize=3 yields mask 3'b111.
  assign w_misal = (i_addr_lo & ((3'd1 << i_asize) - 3'd1)) != 3'd0;
  assign o_fault = (XLEN == 32 && i_asize == AXO_ASIZE_D) || (w_misal && !MISALIGNED);
  assign o_split = w_misal && MISALIGNED;
  assign o_data  = XLEN'(axo_sext(64'(i_data), i_ld_asize, i_ld_signed));
endmodule

// File: rtl/axo_lsu.sv
// axo_lsu: load/store unit between EX and the data bus, splitting or faulting misaligned accesses.
//   req_*  : one load/store per handshake from EX (req_ready high only when idle)
//   resp_* : one-cycle completion pulse with fault flag and extended load data
//   mem_*  : naturally aligned bus access held stable until mem_ready
module axo_lsu import axo_defines::*; #(
  parameter int XLEN       = 32,
  parameter bit MISALIGNED = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_asize,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_fault,
  output logic [XLEN-1:0] resp_rdata,
  output logic            mem_re,
  output logic            mem_we,
  output logic [1:0]      mem_asize,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);
  lsu_state_e r_state, w_next;
  logic r_we, r_signed, r_fault, r_split;
  logic [1:0] r_asize;
  logic [2:0] r_cnt;
  logic [XLEN-1:0] r_addr, r_wdata, r_data;
  logic w_fault, w_split, w_last;
  logic [XLEN-1:0] w_ext;
  axo_lsu_align #(.XLEN(XLEN), .MISALIGNED(MISALIGNED)) u_align (
    .i_asize    (req_asize),
    .i_addr_lo  (req_addr[2:0]),
    .o_fault    (w_fault),
    .o_split    (w_split),
    .i_data     (r_data),
    .i_ld_asize (r_asize),
    .i_ld_signed(r_signed),
    .o_data     (w_ext)
  );
  // A split access walks 2^asize bytes; 3-bit wrap makes asize=3 end at 7.
  assign w_last = !r_split || r_cnt == (3'd1 << r_asize) - 3'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= LSU_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == LSU_IDLE   ? (req_valid ? (w_fault ? LSU_DONE : LSU_ACCESS) : LSU_IDLE) :
             r_state == LSU_ACCESS ? (mem_ready && w_last ? LSU_DONE : LSU_ACCESS) : LSU_IDLE;
    req_ready  = r_state == LSU_IDLE;
    mem_re     = r_state == LSU_ACCESS && !r_we;
    mem_we     = r_state == LSU_ACCESS && r_we;
    mem_asize  = r_split ? AXO_ASIZE_B : r_asize;
    mem_addr   = r_addr + XLEN'(r_cnt);
    mem_wdata  = r_wdata >> {r_cnt, 3'b000};
    resp_valid = r_state == LSU_DONE;
    resp_fault = r_state == LSU_DONE && r_fault;
    resp_rdata = r_state == LSU_DONE && !r_fault && !r_we ? w_ext : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_fault  <= 1'b0;
      r_split  <= 1'b0;
      r_asize  <= 2'd0;
      r_cnt    <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_data   <= '0;
    end else if (r_state == LSU_IDLE && req_valid) begin
      r_we     <= req_we;
      r_signed <= req_signed;
      r_fault  <= w_fault;
      r_split  <= w_split && !w_fault;
      r_asize  <= req_asize;
      r_cnt    <= 3'd0;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_data   <= '0;
    end else if (r_state == LSU_ACCESS && mem_ready) begin
      if (r_split) r_data[{r_cnt, 3'b000} +: 8] <= mem_rdata[7:0];
      else r_data <= mem_rdata;
      r_cnt <= r_cnt + 3'd1;
    end
endmodule

// File: tb/tb_axo_lsu.sv
// tb_axo_lsu: three LSU configurations (32/split, 32/fault, 64/split) driven in lockstep against a behavioural model.
module tb_axo_lsu;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, mem_ready = 1'b0;
  logic [1:0] req_asize = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0, base = '0, pat = '0;
  logic [2:0] rdy, rv, rf, mre, mwe;
  logic [1:0] masz [3];
  logic [63:0] maddr [3], mwd [3], mrsp [3];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
  int m_ph [3], m_k [3], m_n [3];
  logic [63:0] m_base [3], m_wd [3], m_rd [3];
  logic [1:0] m_asz [3];
  logic m_we [3], m_fault [3], m_split [3];
  int last_lat [3], resp_cnt [3], log_n [3];
  logic [63:0] last_rd [3], log_addr [3][8], log_data [3][8];
  logic [1:0] log_sz [3][8];
  logic last_f [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int XL = g == 2 ? 64 : 32;
    localparam bit MS = g != 1;
    logic [XL-1:0] w_addr, w_wdata, w_rdata, w_resp, w_off;
    axo_lsu #(.XLEN(XL), .MISALIGNED(MS)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[g]), .req_we(req_we),
      .req_asize(req_asize), .req_signed(req_signed), .req_addr(req_addr[XL-1:0]),
      .req_wdata(req_wdata[XL-1:0]), .resp_valid(rv[g]), .resp_fault(rf[g]), .resp_rdata(w_resp),
      .mem_re(mre[g]), .mem_we(mwe[g]), .mem_asize(masz[g]), .mem_addr(w_addr),
      .mem_wdata(w_wdata), .mem_rdata(w_rdata), .mem_ready(mem_ready)
    );
    // The bus is a memory window whose byte at base+j is pat byte j.
    assign w_off    = w_addr - base[XL-1:0];
    assign w_rdata  = XL'(pat >> {w_off[2:0], 3'b000});
    assign maddr[g] = 64'(w_addr);
    assign mwd[g]   = 64'(w_wdata);
    assign mrsp[g]  = 64'(w_resp);
  end

  function automatic int xl(int g); return g == 2 ? 64 : 32; endfunction
  function automatic bit mis_en(int g); return g != 1; endfunction
  function automatic logic [63:0] xmask(int g); return xl(g) == 64 ? '1 : 64'hFFFF_FFFF; endfunction
  function automatic bit misal(logic [63:0] a, logic [1:0] s); return (a % (64'd1 << s)) != 0; endfunction
  function automatic bit flt(int g, logic [63:0] a, logic [1:0] s);
    return (xl(g) == 32 && s == 2'd3) || (misal(a, s) && !mis_en(g));
  endfunction
  function automatic logic [63:0] ext(int g, logic [1:0] s, logic sgn, logic [63:0] v);
    int bits;
    logic [63:0] m;
    bits = 8 << s;
    if (bits >= xl(g)) return v & xmask(g);
    m = (64'd1 << bits) - 64'd1;
    if (sgn && v[bits-1]) return (v | ~m) & xmask(g);
    return v & m;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst)
    for (int g = 0; g < 3; g++)
      if (rst) m_ph[g] <= 0;
      else if (m_ph[g] == 0) begin
        if (req_valid) begin
          m_base[g]  <= req_addr & xmask(g);
          m_asz[g]   <= req_asize;
          m_we[g]    <= req_we;
          m_wd[g]    <= req_wdata & xmask(g);
          m_k[g]     <= 0;
          m_fault[g] <= flt(g, req_addr, req_asize);
          m_split[g] <= misal(req_addr, req_asize);
          m_n[g]     <= misal(req_addr, req_asize) ? (1 << req_asize) : 1;
          m_rd[g]    <= ext(g, req_asize, req_signed, pat);
          m_ph[g]    <= flt(g, req_addr, req_asize) ? 2 : 1;
        end
      end else if (m_ph[g] == 1) begin
        if (mem_ready) begin
          if (m_k[g] + 1 == m_n[g]) m_ph[g] <= 2;
          else m_k[g] <= m_k[g] + 1;
        end
      end else m_ph[g] <= 0;

  always @(negedge clk) begin
    logic [63:0] off;
    if (!rst)
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("dut%0d req_ready", g), 64'(rdy[g]), 64'(m_ph[g] == 0));
        chk($sformatf("dut%0d mem_re", g), 64'(mre[g]), 64'(m_ph[g] == 1 && !m_we[g]));
        chk($sformatf("dut%0d mem_we", g), 64'(mwe[g]), 64'(m_ph[g] == 1 && m_we[g]));
        if (m_ph[g] == 1) begin
          off = m_split[g] ? 64'(m_k[g]) : 64'd0;
          chk($sformatf("dut%0d mem_addr", g), maddr[g], (m_base[g] + off) & xmask(g));
          chk($sformatf("dut%0d mem_asize", g), 64'(masz[g]), m_split[g] ? 64'd0 : 64'(m_asz[g]));
          chk($sformatf("dut%0d mem_wdata", g), mwd[g], m_wd[g] >> (off * 8));
        end
        if ((mre[g] || mwe[g]) && mem_ready && log_n[g] < 8) begin
          log_addr[g][log_n[g]] = maddr[g];
          log_data[g][log_n[g]] = mwd[g];
          log_sz[g][log_n[g]] = masz[g];
          log_n[g]++;
        end
        chk($sformatf("dut%0d resp_valid", g), 64'(rv[g]), 64'(m_ph[g] == 2));
        if (m_ph[g] == 2) begin
          chk($sformatf("dut%0d resp_fault", g), 64'(rf[g]), 64'(m_fault[g]));
          chk($sformatf("dut%0d resp_rdata", g), mrsp[g], m_fault[g] || m_we[g] ? 64'd0 : m_rd[g]);
        end
        if (rv[g]) begin
          last_lat[g] = cyc - acc_cyc;
          last_rd[g] = mrsp[g];
          last_f[g] = rf[g];
          resp_cnt[g]++;
        end
      end
  end

  task automatic run(input logic we, input logic [1:0] s, input logic sg, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] p, input int stall);
    bit done;
    for (int g = 0; g < 3; g++) log_n[g] = 0;
    req_we = we; req_asize = s; req_signed = sg; req_addr = a; req_wdata = wd;
    base = a; pat = p; mem_ready = 1'b0; req_valid = 1'b1; acc_cyc = cyc;
    @(posedge clk); #1 req_valid = 1'b0;
    done = 0;
    for (int t = 1; t < 40 && !done; t++) begin
      mem_ready = t > stall;
      @(posedge clk); #1;
      done = &rdy;
    end
    mem_ready = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout act=busy exp=idle addr=%h", a);
    end
  endtask

  initial begin
    int rc;
    for (int g = 0; g < 3; g++) begin resp_cnt[g] = 0; log_n[g] = 0; end
    #12;
    chk("reset req_ready", 64'(rdy), 64'b111);
    chk("reset resp_valid", 64'(rv), 0);
    chk("reset resp_fault", 64'(rf), 0);
    chk("reset mem_en", 64'({mre, mwe}), 0);
    for (int g = 0; g < 3; g++) begin
      chk("reset mem_addr", maddr[g], 0);
      chk("reset mem_wdata", mwd[g], 0);
      chk("reset mem_asize", 64'(masz[g]), 0);
      chk("reset resp_rdata", mrsp[g], 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    run(0, 2, 0, 64'h100, 0, 64'hDEADBEEF, 0);
    chk("lw rdata", last_rd[0], 64'hDEADBEEF);
    chk("lw latency", 64'(last_lat[0]), 2);
    chk("lw accesses", 64'(log_n[0]), 1);
    chk("lw bus size", 64'(log_sz[0][0]), 2);
    run(0, 0, 1, 64'h101, 0, 64'h80, 0);
    chk("lb signed", last_rd[0], 64'hFFFFFF80);
    chk("lb signed 64", last_rd[2], 64'hFFFFFFFFFFFFFF80);
    run(0, 0, 0, 64'h101, 0, 64'hABCD80, 0);
    chk("lbu", last_rd[0], 64'h80);
    run(1, 1, 0, 64'h103, 64'hA55A, 0, 0);
    chk("sh split count", 64'(log_n[0]), 2);
    chk("sh byte0 addr", log_addr[0][0], 64'h103);
    chk("sh byte0 data", 64'(log_data[0][0][7:0]), 64'h5A);
    chk("sh byte1 addr", log_addr[0][1], 64'h104);
    chk("sh byte1 data", 64'(log_data[0][1][7:0]), 64'hA5);
    chk("sh fault", 64'(last_f[0]), 0);
    chk("sh latency", 64'(last_lat[0]), 3);
    chk("sh nosplit fault", 64'(last_f[1]), 1);
    run(0, 2, 0, 64'h102, 0, 64'h11223344, 0);
    chk("lw mis fault", 64'(last_f[1]), 1);
    chk("lw mis fault rdata", last_rd[1], 0);
    chk("lw mis fault latency", 64'(last_lat[1]), 1);
    chk("lw mis fault bus", 64'(log_n[1]), 0);
    chk("lw mis split rdata", last_rd[0], 64'h11223344);
    chk("lw mis split latency", 64'(last_lat[0]), 5);
    run(0, 3, 0, 64'h100, 0, 64'h0123456789ABCDEF, 0);
    chk("ld rv32 fault", 64'(last_f[0]), 1);
    chk("ld rv32 rdata", last_rd[0], 0);
    chk("ld rv32 latency", 64'(last_lat[0]), 1);
    chk("ld rv32 bus", 64'(log_n[0]), 0);
    chk("ld rv64 rdata", last_rd[2], 64'h0123456789ABCDEF);
    run(0, 2, 0, 64'h100, 0, 64'hCAFEF00D, 3);
    chk("stall latency", 64'(last_lat[0]), 5);
    chk("stall rdata", last_rd[0], 64'hCAFEF00D);
    for (int g = 0; g < 3; g++) log_n[g] = 0;
    req_we = 0; req_asize = 2; req_signed = 0; req_addr = 64'h200; base = 64'h200; pat = 64'h55;
    mem_ready = 1'b0; req_valid = 1'b1; acc_cyc = cyc;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("rst mem_re", 64'(mre), 0);
    chk("rst req_ready", 64'(rdy), 64'b111);
    chk("rst resp_valid", 64'(rv), 0);
    rc = resp_cnt[0];
    @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("rst no response", 64'(resp_cnt[0]), 64'(rc));
    chk("rst idle", 64'(rdy), 64'b111);
    run(0, 2, 1, 64'h100, 0, 64'h80000000, 0);
    chk("lw signed 64", last_rd[2], 64'hFFFFFFFF80000000);
    chk("lw signed 32", last_rd[0], 64'h80000000);
    run(0, 2, 0, 64'hFFFFFFFFFFFFFFFE, 0, 64'hA1B2C3D4, 0);
    chk("wrap addr0", log_addr[2][0], 64'hFFFFFFFFFFFFFFFE);
    chk("wrap addr1", log_addr[2][1], 64'hFFFFFFFFFFFFFFFF);
    chk("wrap addr2", log_addr[2][2], 64'h0);
    chk("wrap addr3", log_addr[2][3], 64'h1);
    chk("wrap rdata", last_rd[2], 64'hA1B2C3D4);
    chk("wrap rv32 addr2", log_addr[0][2], 64'h0);
    run(1, 2, 0, 64'h208, 64'h12345678, 0, 0);
    chk("sw wdata", log_data[0][0], 64'h12345678);
    chk("sw rdata", last_rd[0], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
